// File: rtl/seq_divider_8.sv
// ============================================================================
// Module   : seq_divider_8
// Purpose  : Sequential 8-bit unsigned restoring divider. Performs one trial
//            subtraction per clock through an external ripple add/subtract
//            stage (driven via add_* and read back combinationally through
//            add_s/add_cout in the same cycle). Fixed 8 iterations per
//            division; a zero divisor short-circuits straight to DONE.
// Ports    : clk, rst            - clock (rising edge), async active-high reset
//            start               - division request, sampled only in IDLE
//            dividend, divisor   - operands, latched on an accepted start
//            busy, done          - CALC indicator, one-cycle result strobe
//            quotient, remainder - registered results, held until next done
//            div_by_zero         - registered flag, updated with done
//            add_sub/add_a/add_b - operands to the adder stage
//            add_s/add_cout      - adder stage result / borrow (1 => A < B)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             add_sub,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] c_last_cnt = 3'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;

  // The partial remainder is below 2^k after k iterations and is only fed
  // back for iterations 1..7, so its top bit is never needed in the register;
  // the final full-width remainder is taken directly from w_rem_next.
  logic [WIDTH-2:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [2:0]       r_cnt;

  logic             w_accept;
  logic             w_zero_div;
  logic [WIDTH-1:0] w_tmp;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_zero_div = (divisor == '0);

  // Shift the next dividend bit into the partial remainder; the adder stage
  // tries tmp - D and a borrow means the trial failed (restore tmp).
  assign w_tmp      = {r_rem, r_q[WIDTH-1]};
  assign w_qbit     = ~add_cout;
  assign w_rem_next = add_cout ? w_tmp : add_s;
  assign w_q_next   = {r_q[WIDTH-2:0], w_qbit};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = w_zero_div ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == c_last_cnt) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (decoded from state so reset clears it immediately)
  // --------------------------------------------------------------------------
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    add_sub = 1'b0;
    add_a   = '0;
    add_b   = '0;
    case (r_state)
      S_CALC: begin
        busy    = 1'b1;
        add_sub = 1'b1;
        add_a   = w_tmp;
        add_b   = r_d;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_zero_div) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end else begin
          r_d   <= divisor;
          r_q   <= dividend;
          r_rem <= '0;
          r_cnt <= '0;
        end
      end else if (r_state == S_CALC) begin
        r_rem <= w_rem_next[WIDTH-2:0];
        r_q   <= w_q_next;
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == c_last_cnt) begin
          quotient    <= w_q_next;
          remainder   <= w_rem_next;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire
